counter_host: RTL and testbench
===============================

# counter_host

Host-side controller for the 8-bit counter chip's bidirectional bus. Turns single-command requests (READ, LOAD) into the chip's pin protocol: load_n and oe_n strobes, bus drive with turnaround, and synchronized sampling of the free-running count. It returns one response per command. It sits between on-board logic or a test harness and the counter chip's load_n, oe_n and 8-bit IO pins.

## Interface
Parameters:
- LOAD_PULSE_CYCLES, 2, cycles load_n is held low during LOAD (min 1)
- SETTLE_CYCLES, 2, extra cycles after oe_n falls before first sample (min 0)
- MAX_RETRY, 3, re-sample attempts before READ reports error (min 0)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; command accepted on clk edge with cmd_valid && cmd_ready
- cmd_op  in  1  0 = READ, 1 = LOAD
- cmd_data  in  8  LOAD value; ignored for READ
- rsp_valid  out  1  one-cycle response strobe, no backpressure
- rsp_data  out  8  READ result, or echo of loaded value; held until next rsp_valid
- rsp_err  out  1  READ failed stability check; qualified by rsp_valid
- load_n  out  1  chip load strobe, active-low
- oe_n  out  1  chip output enable, active-low
- bus_in  in  8  chip IO pins, input path (asynchronous to clk)
- bus_out  out  8  chip IO pins, output path
- bus_oe  out  1  host drives bus when high

## Operation
- Reset values: cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, load_n=1, oe_n=1, bus_oe=0, bus_out=0; state IDLE, retry count 0.
- bus_in passes a 2-FF synchronizer before any use. Raw bus_in never reaches logic.
- States: IDLE, L_SETUP, L_PULSE, L_HOLD, L_TURN, R_WAIT, R_SAMP_A, R_SAMP_B, R_DONE.
- LOAD path: IDLE -> L_SETUP (bus_oe=1, bus_out=cmd_data, load_n=1) -> L_PULSE for LOAD_PULSE_CYCLES (load_n=0, bus still driven) -> L_HOLD 1 cycle (load_n=1, bus still driven) -> L_TURN 1 cycle (bus_oe=0, rsp_valid=1, rsp_data=loaded value, rsp_err=0) -> IDLE.
- READ path: IDLE -> R_WAIT for SETTLE_CYCLES+2 cycles (oe_n=0, bus_oe=0) -> R_SAMP_A (capture synchronized bus as s1) -> R_SAMP_B (capture s2).
- READ stability check: s2 is accepted if s2 == s1 or s2 == s1+1 mod 256; 8'hFF -> 8'h00 counts as +1. This tolerates a running counter.
- On accept: R_DONE (oe_n=1, rsp_valid=1, rsp_data=s2, rsp_err=0) -> IDLE.
- On reject with retries < MAX_RETRY: increment retries, return to R_SAMP_A with oe_n held low.
- On reject with retries == MAX_RETRY: R_DONE with rsp_data=s2, rsp_err=1.
- Retry counter clears on entry to IDLE.
- Commands are accepted only in IDLE. cmd_valid during a command is ignored and is not queued.
- Invariants:
  - bus_oe and !oe_n are never both 1 (no contention).
  - load_n=0 only while bus_oe=1.
  - oe_n=1 in every LOAD state.
- Asynchronous reset mid-command forces all reset values immediately, including bus_oe=0 and load_n=1. No response is issued for the aborted command.

## Timing
Cycle 0 = the edge where the command is accepted.
- LOAD: L_SETUP in cycle 1; load_n low in cycles 2..LOAD_PULSE_CYCLES+1; L_HOLD, L_TURN and rsp_valid follow. With defaults: rsp_valid in cycle 5, cmd_ready=1 in cycle 6.
- READ: oe_n low from cycle 1. First sample at cycle SETTLE_CYCLES+3. rsp_valid at cycle SETTLE_CYCLES+5 with no retry; each retry adds 2 cycles. With defaults: rsp_valid in cycle 7, cmd_ready in cycle 8.
- oe_n rises in the rsp_valid cycle. A READ issued back-to-back after a LOAD sees bus_oe=0 for at least 1 cycle before oe_n falls.
- Outputs are all registered. No combinational path from cmd_* or bus_in to any output.

## Structure
- Shared package counter_host_pkg: state enum, OP_READ/OP_LOAD constants, bus width constant (8).
- One sub-module: sync_2ff, width-parameterized, used for bus_in.
- Everything else (FSM, cycle counter, retry counter, sample registers) stays in counter_host.

## Test plan
- Reset: hold rst_n=0 with cmd_valid=1 -> every output at its reset value and no accept; release -> cmd_ready=1.
- LOAD 8'hA5 with defaults -> load_n low exactly cycles 2-3, bus_out=A5 with bus_oe=1 in cycles 1-4, rsp_valid in cycle 5 with rsp_data=A5, rsp_err=0.
- READ with a static bus model at 8'h3C -> oe_n low cycles 1-6, rsp_valid in cycle 7, rsp_data=3C, rsp_err=0. Contention assertion never fires.
- READ against a counter model stepping every clk across FF->00 -> rsp_err=0, rsp_data equals model value two cycles earlier.
- READ against a bus alternating 00/55 each cycle, MAX_RETRY=3 -> 4 sample pairs, rsp_err=1, rsp_valid in cycle 13.
- Assert rst_n during L_PULSE -> load_n=1 and bus_oe=0 asynchronously, no rsp_valid; a following READ completes normally.

Source files
------------

// File: rtl/counter_host_pkg.sv
// Shared types and constants for the counter-chip host controller.
package counter_host_pkg;

    localparam int unsigned BUS_W = 8;

    localparam logic OP_READ = 1'b0;
    localparam logic OP_LOAD = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        L_SETUP,
        L_PULSE,
        L_HOLD,
        L_TURN,
        R_WAIT,
        R_SAMP_A,
        R_SAMP_B,
        R_DONE
    } state_e;

    // A free-running counter may advance by one between the two samples; 8'hFF -> 8'h00 wraps.
    function automatic logic sample_stable(input logic [BUS_W-1:0] s1,
                                           input logic [BUS_W-1:0] s2);
        return (s2 == s1) || (s2 == s1 + BUS_W'(1));
    endfunction

endpackage

// File: rtl/counter_host_if.sv
// Command/response handshake between on-board logic and the counter host.
interface counter_host_if;
    import counter_host_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_op;
    logic [BUS_W-1:0] cmd_data;
    logic             rsp_valid;
    logic [BUS_W-1:0] rsp_data;
    logic             rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/counter_host_sync_2ff.sv
// Two-flop synchronizer for the chip's asynchronous bus input.
module sync_2ff #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/counter_host.sv
// Host-side controller driving the counter chip's load_n/oe_n strobes and shared bus.
module counter_host
    import counter_host_pkg::*;
#(
    parameter int unsigned LOAD_PULSE_CYCLES = 2,
    parameter int unsigned SETTLE_CYCLES     = 2,
    parameter int unsigned MAX_RETRY         = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    counter_host_if.slave    host,
    output logic             load_n,
    output logic             oe_n,
    input  logic [BUS_W-1:0] bus_in,
    output logic [BUS_W-1:0] bus_out,
    output logic             bus_oe
);

    localparam int unsigned WAIT_CYCLES = SETTLE_CYCLES + 2;
    localparam int unsigned CNT_MAX     = (LOAD_PULSE_CYCLES > WAIT_CYCLES) ? LOAD_PULSE_CYCLES
                                                                           : WAIT_CYCLES;
    localparam int unsigned CW          = $clog2(CNT_MAX);
    localparam int unsigned RW          = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [RW-1:0]    retry_q;
    logic [BUS_W-1:0] s1_q;
    logic             cmd_ready_q;
    logic             rsp_valid_q;
    logic [BUS_W-1:0] rsp_data_q;
    logic             rsp_err_q;
    logic             load_n_q;
    logic             oe_n_q;
    logic [BUS_W-1:0] bus_out_q;
    logic             bus_oe_q;

    logic [BUS_W-1:0] bus_sync;
    logic             stable;

    sync_2ff #(.WIDTH(BUS_W)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus_in),
        .q_o   (bus_sync)
    );

    assign stable = sample_stable(s1_q, bus_sync);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            retry_q     <= '0;
            s1_q        <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            load_n_q    <= 1'b1;
            oe_n_q      <= 1'b1;
            bus_out_q   <= '0;
            bus_oe_q    <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (host.cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        if (host.cmd_op == OP_LOAD) begin
                            state_q   <= L_SETUP;
                            bus_oe_q  <= 1'b1;
                            bus_out_q <= host.cmd_data;
                        end else begin
                            state_q <= R_WAIT;
                            oe_n_q  <= 1'b0;
                            cnt_q   <= CW'(WAIT_CYCLES - 1);
                        end
                    end
                end
                L_SETUP: begin
                    state_q  <= L_PULSE;
                    load_n_q <= 1'b0;
                    cnt_q    <= CW'(LOAD_PULSE_CYCLES - 1);
                end
                L_PULSE: begin
                    if (cnt_q == '0) begin
                        state_q  <= L_HOLD;
                        load_n_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                L_HOLD: begin
                    state_q     <= L_TURN;
                    bus_oe_q    <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= bus_out_q;
                    rsp_err_q   <= 1'b0;
                end
                L_TURN: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                    retry_q     <= '0;
                end
                R_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= R_SAMP_A;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                R_SAMP_A: begin
                    s1_q    <= bus_sync;
                    state_q <= R_SAMP_B;
                end
                R_SAMP_B: begin
                    // The second sample is judged and reported on the same edge it is taken.
                    if (stable || (retry_q == RW'(MAX_RETRY))) begin
                        state_q     <= R_DONE;
                        oe_n_q      <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= bus_sync;
                        rsp_err_q   <= !stable;
                    end else begin
                        retry_q <= retry_q + RW'(1);
                        state_q <= R_SAMP_A;
                    end
                end
                R_DONE: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                    retry_q     <= '0;
                end
                default: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                    load_n_q    <= 1'b1;
                    oe_n_q      <= 1'b1;
                    bus_oe_q    <= 1'b0;
                    retry_q     <= '0;
                end
            endcase
        end
    end

    assign host.cmd_ready = cmd_ready_q;
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_data  = rsp_data_q;
    assign host.rsp_err   = rsp_err_q;
    assign load_n         = load_n_q;
    assign oe_n           = oe_n_q;
    assign bus_out        = bus_out_q;
    assign bus_oe         = bus_oe_q;

endmodule

// File: tb/tb_counter_host.sv
// Directed bench for counter_host: LOAD/READ timing, stability check, retries and async abort.
module tb_counter_host;
    import counter_host_pkg::*;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic [7:0] bus_in = 8'h00;
    logic       load_n;
    logic       oe_n;
    logic [7:0] bus_out;
    logic       bus_oe;

    counter_host_if ch_if ();

    counter_host #(
        .LOAD_PULSE_CYCLES (2),
        .SETTLE_CYCLES     (2),
        .MAX_RETRY         (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .host    (ch_if),
        .load_n  (load_n),
        .oe_n    (oe_n),
        .bus_in  (bus_in),
        .bus_out (bus_out),
        .bus_oe  (bus_oe)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp    = 0;
    int unsigned n_bad    = 0;
    int unsigned inv_viol = 0;

    // Per-cycle activity, bit k = cycle k after the accept edge.
    logic [15:0] v_ld, v_oe, v_rd, v_rv, v_rdy, v_bus;
    logic [7:0]  r_data;
    logic        r_err;
    int unsigned n_rsp;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_oe && !oe_n)  inv_viol++;
            if (!load_n && !bus_oe) inv_viol++;
            if (!load_n && !oe_n)   inv_viol++;
        end
    end

    task automatic issue(input logic op, input logic [7:0] data, input logic [7:0] bus0,
                         input string tag);
        @(negedge clk);
        expect_eq({tag, "_ready"}, ch_if.cmd_ready, 1);
        ch_if.cmd_valid = 1'b1;
        ch_if.cmd_op    = op;
        ch_if.cmd_data  = data;
        bus_in          = bus0;
        @(posedge clk);
        #1;
        ch_if.cmd_valid = 1'b0;
    endtask

    // mode 0: bus static, 1: bus = base + k at edge k, 2: bus = 00 on even / 55 on odd edges
    task automatic observe(input int unsigned n, input int unsigned mode, input logic [7:0] base,
                           input int unsigned poke_cycle);
        v_ld = '0; v_oe = '0; v_rd = '0; v_rv = '0; v_rdy = '0; v_bus = '0;
        r_data = '0; r_err = 1'b0; n_rsp = 0;
        for (int unsigned k = 1; k <= n; k++) begin
            v_ld[k]  = !load_n;
            v_oe[k]  = bus_oe;
            v_rd[k]  = !oe_n;
            v_rv[k]  = ch_if.rsp_valid;
            v_rdy[k] = ch_if.cmd_ready;
            v_bus[k] = bus_oe && (bus_out == base);
            if (ch_if.rsp_valid) begin
                n_rsp++;
                r_data = ch_if.rsp_data;
                r_err  = ch_if.rsp_err;
            end
            if (mode == 1) bus_in = base + 8'(k);
            if (mode == 2) bus_in = k[0] ? 8'h55 : 8'h00;
            if (k == poke_cycle) begin
                ch_if.cmd_valid = 1'b1;
                ch_if.cmd_op    = OP_READ;
            end else begin
                ch_if.cmd_valid = 1'b0;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        ch_if.cmd_valid = 1'b1;
        ch_if.cmd_op    = OP_LOAD;
        ch_if.cmd_data  = 8'hFF;

        // Reset held with a pending command
        repeat (3) @(negedge clk);
        expect_eq("rst_ctrl", {ch_if.cmd_ready, ch_if.rsp_valid, ch_if.rsp_err,
                               load_n, oe_n, bus_oe}, 6'b100110);
        expect_eq("rst_rsp_data", ch_if.rsp_data, 8'h00);
        expect_eq("rst_bus_out", bus_out, 8'h00);
        ch_if.cmd_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_eq("rel_ctrl", {ch_if.cmd_ready, load_n, oe_n, bus_oe}, 4'b1110);

        // LOAD A5 with a stray cmd_valid mid-command
        issue(OP_LOAD, 8'hA5, 8'h00, "load");
        observe(7, 0, 8'hA5, 3);
        expect_eq("load_n_low", v_ld, 16'h000C);
        expect_eq("load_bus_oe", v_oe, 16'h001E);
        expect_eq("load_bus_out", v_bus, 16'h001E);
        expect_eq("load_oe_n", v_rd, 16'h0000);
        expect_eq("load_rsp_valid", v_rv, 16'h0020);
        expect_eq("load_ready", v_rdy, 16'h00C0);
        expect_eq("load_rsp", {r_err, r_data}, 9'h0A5);

        // Async reset during L_PULSE
        issue(OP_LOAD, 8'h5A, 8'h00, "abort");
        @(posedge clk);
        #1;
        expect_eq("abort_in_pulse", load_n, 0);
        #2 rst_n = 1'b0;
        #1;
        expect_eq("abort_ctrl", {load_n, bus_oe, oe_n, ch_if.cmd_ready, ch_if.rsp_valid},
                  5'b10110);
        expect_eq("abort_rsp_data", ch_if.rsp_data, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        observe(6, 0, 8'h00, 0);
        expect_eq("abort_no_rsp", n_rsp, 0);
        expect_eq("abort_no_strobe", v_ld | v_rd | v_oe, 16'h0000);

        // READ, static bus 3C
        bus_in = 8'h3C;
        repeat (3) @(posedge clk);
        issue(OP_READ, 8'h00, 8'h3C, "rd_static");
        observe(8, 0, 8'h3C, 0);
        expect_eq("rd_static_oe_n", v_rd, 16'h007E);
        expect_eq("rd_static_bus_oe", v_oe, 16'h0000);
        expect_eq("rd_static_rsp_valid", v_rv, 16'h0080);
        expect_eq("rd_static_ready", v_rdy, 16'h0100);
        expect_eq("rd_static_rsp", {r_err, r_data}, 9'h03C);

        // READ, running counter crossing FF->00 between samples
        issue(OP_READ, 8'h00, 8'hFC, "rd_count");
        observe(8, 1, 8'hFC, 0);
        expect_eq("rd_count_rsp_valid", v_rv, 16'h0080);
        expect_eq("rd_count_rsp", {r_err, r_data}, 9'h000);

        // READ, bus alternating 00/55: every pair rejected, retries exhausted
        issue(OP_READ, 8'h00, 8'h00, "rd_alt");
        observe(14, 2, 8'h00, 0);
        expect_eq("rd_alt_oe_n", v_rd, 16'h1FFE);
        expect_eq("rd_alt_rsp_valid", v_rv, 16'h2000);
        expect_eq("rd_alt_ready", v_rdy, 16'h4000);
        expect_eq("rd_alt_rsp", {r_err, r_data}, 9'h100);

        expect_eq("invariants", inv_viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
